// File: rtl/pri_iter_pkg.sv
// pri_iter_pkg: shared state type for the set-bit iterator
package pri_iter_pkg;
  typedef enum logic {IDLE, ITER} state_t;
endpackage

// File: rtl/onehot_enc.sv
// onehot_enc: one-hot to binary encoder; zero input gives zero
module onehot_enc #(
  parameter int W = 32,
  localparam int IDX_W = $clog2(W)
) (
  input  logic [W-1:0]     onehot,
  output logic [IDX_W-1:0] idx
);
  always_comb begin
    idx = '0;
    for (int i = 0; i < W; i++)
      idx = idx | (onehot[i] ? i[IDX_W-1:0] : '0);
  end
endmodule

// File: rtl/pri.sv
// pri: isolates the highest-priority set bit of x as a one-hot vector
module pri #(
  parameter int W = 32,
  parameter bit FROM_LSB = 1'b0
) (
  input  logic [W-1:0] x,
  output logic [W-1:0] onehot
);
  logic [W-1:0] rev, rev_oh;
  for (genvar i = 0; i < W; i++) begin : g_rev
    assign rev[i] = x[W-1-i];
  end
  // two's-complement trick keeps only the lowest set bit
  assign rev_oh = rev & (~rev + 1'b1);
  logic [W-1:0] lsb_oh, msb_oh;
  assign lsb_oh = x & (~x + 1'b1);
  for (genvar i = 0; i < W; i++) begin : g_unrev
    assign msb_oh[i] = rev_oh[W-1-i];
  end
  assign onehot = FROM_LSB ? lsb_oh : msb_oh;
endmodule

// File: rtl/pri_iter.sv
// pri_iter: emits the index of each set bit of an accepted vector, one per cycle
module pri_iter
  import pri_iter_pkg::*;
#(
  parameter int W = 32,
  parameter bit FROM_LSB = 1'b0,
  localparam int IDX_W = $clog2(W)
) (
  input  logic             clk,
  input  logic             arst,
  input  logic             i_x_vld,
  input  logic [W-1:0]     i_x,
  output logic             o_x_rdy,
  output logic             o_idx_vld,
  output logic [IDX_W-1:0] o_idx,
  output logic             o_idx_last,
  input  logic             i_idx_rdy,
  output logic             o_busy
);
  state_t state;
  logic [W-1:0] residual, onehot, nxt;
  logic [IDX_W-1:0] enc;
  logic load;
  pri #(.W(W), .FROM_LSB(FROM_LSB)) u_pri (.x(residual), .onehot(onehot));
  onehot_enc #(.W(W)) u_enc (.onehot(onehot), .idx(enc));
  assign nxt        = residual & ~onehot;
  assign o_busy     = state == ITER;
  assign o_idx_vld  = o_busy;
  assign o_idx      = o_busy ? enc : '0;
  assign o_idx_last = o_busy & (nxt == '0);
  assign o_x_rdy    = !o_busy | (o_idx_last & i_idx_rdy);
  // a zero vector is consumed by the handshake but never loaded
  assign load       = i_x_vld & o_x_rdy & (|i_x);
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      state    <= IDLE;
      residual <= '0;
    end else if (load) begin
      state    <= ITER;
      residual <= i_x;
    end else if (o_busy & i_idx_rdy) begin
      residual <= nxt;
      if (o_idx_last) state <= IDLE;
    end
  end
  a_onehot: assert property (@(posedge clk) disable iff (arst) $onehot0(onehot));
  a_resid: assert property (@(posedge clk) disable iff (arst) !o_idx_vld || residual != '0);
endmodule

// File: tb/tb_pri_iter.sv
// tb_pri_iter: directed table, reset sequence and random model check for pri_iter
module tb_pri_iter;
  logic clk = 0, arst = 1, x_vld = 0, idx_rdy = 0;
  logic [7:0] x = '0;
  logic l_xrdy, l_vld, l_last, l_busy, m_xrdy, m_vld, m_last, m_busy;
  logic [2:0] l_idx, m_idx;
  int total = 0, bad = 0;
  int ql[$], qm[$];

  always #5 clk = ~clk;

  pri_iter #(.W(8), .FROM_LSB(1'b1)) dut_l (
    .clk(clk), .arst(arst), .i_x_vld(x_vld), .i_x(x), .o_x_rdy(l_xrdy),
    .o_idx_vld(l_vld), .o_idx(l_idx), .o_idx_last(l_last), .i_idx_rdy(idx_rdy), .o_busy(l_busy));
  pri_iter #(.W(8), .FROM_LSB(1'b0)) dut_m (
    .clk(clk), .arst(arst), .i_x_vld(x_vld), .i_x(x), .o_x_rdy(m_xrdy),
    .o_idx_vld(m_vld), .o_idx(m_idx), .o_idx_last(m_last), .i_idx_rdy(idx_rdy), .o_busy(m_busy));

  typedef struct {
    bit xv; bit [7:0] x; bit rdy;
    bit vld; int il; bit ll; int im; bit lm; bit xrdy;
  } row_t;
  row_t tbl[$];

  task automatic chk(input string n, input int a, input int e);
    total++;
    if (a != e) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", n, a, e);
    end
  endtask

  task automatic chk_both(input string n, input bit vld, input int il, input bit ll,
                          input int im, input bit lm, input bit xrdy);
    chk({n, " l_vld"}, l_vld, vld);   chk({n, " m_vld"}, m_vld, vld);
    chk({n, " l_busy"}, l_busy, vld); chk({n, " m_busy"}, m_busy, vld);
    chk({n, " l_idx"}, l_idx, il);    chk({n, " m_idx"}, m_idx, im);
    chk({n, " l_last"}, l_last, ll);  chk({n, " m_last"}, m_last, lm);
    chk({n, " l_xrdy"}, l_xrdy, xrdy); chk({n, " m_xrdy"}, m_xrdy, xrdy);
  endtask

  function automatic row_t r(bit xv, bit [7:0] xx, bit rdy, bit vld,
                             int il, bit ll, int im, bit lm, bit xrdy);
    row_t t;
    t.xv = xv; t.x = xx; t.rdy = rdy; t.vld = vld;
    t.il = il; t.ll = ll; t.im = im; t.lm = lm; t.xrdy = xrdy;
    return t;
  endfunction

  initial begin
    // vector 0xA4, free-flowing
    tbl.push_back(r(1, 8'hA4, 1, 0, 0, 0, 0, 0, 1));
    tbl.push_back(r(0, 8'h00, 1, 1, 2, 0, 7, 0, 0));
    tbl.push_back(r(0, 8'h00, 1, 1, 5, 0, 5, 0, 0));
    tbl.push_back(r(0, 8'h00, 1, 1, 7, 1, 2, 1, 1));
    tbl.push_back(r(0, 8'h00, 1, 0, 0, 0, 0, 0, 1));
    // 0xA4 with three stalled cycles on the middle index
    tbl.push_back(r(1, 8'hA4, 1, 0, 0, 0, 0, 0, 1));
    tbl.push_back(r(0, 8'h00, 1, 1, 2, 0, 7, 0, 0));
    tbl.push_back(r(0, 8'h00, 0, 1, 5, 0, 5, 0, 0));
    tbl.push_back(r(0, 8'h00, 0, 1, 5, 0, 5, 0, 0));
    tbl.push_back(r(0, 8'h00, 0, 1, 5, 0, 5, 0, 0));
    tbl.push_back(r(0, 8'h00, 1, 1, 5, 0, 5, 0, 0));
    tbl.push_back(r(0, 8'h00, 1, 1, 7, 1, 2, 1, 1));
    tbl.push_back(r(0, 8'h00, 1, 0, 0, 0, 0, 0, 1));
    // zero vector
    tbl.push_back(r(1, 8'h00, 1, 0, 0, 0, 0, 0, 1));
    tbl.push_back(r(0, 8'h00, 1, 0, 0, 0, 0, 0, 1));
    // back-to-back 0x81 then 0x10
    tbl.push_back(r(1, 8'h81, 1, 0, 0, 0, 0, 0, 1));
    tbl.push_back(r(1, 8'h10, 1, 1, 0, 0, 7, 0, 0));
    tbl.push_back(r(1, 8'h10, 1, 1, 7, 1, 0, 1, 1));
    tbl.push_back(r(0, 8'h00, 1, 1, 4, 1, 4, 1, 1));
    tbl.push_back(r(0, 8'h00, 1, 0, 0, 0, 0, 0, 1));

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_both("reset", 0, 0, 0, 0, 0, 1);
    arst = 0;
    @(posedge clk); #1;

    foreach (tbl[k]) begin
      x_vld = tbl[k].xv; x = tbl[k].x; idx_rdy = tbl[k].rdy;
      @(negedge clk);
      chk_both($sformatf("row%0d", k), tbl[k].vld, tbl[k].il, tbl[k].ll,
               tbl[k].im, tbl[k].lm, tbl[k].xrdy);
      @(posedge clk); #1;
    end

    // asynchronous reset in the middle of 0xFF
    x_vld = 1; x = 8'hFF; idx_rdy = 1;
    @(posedge clk); #1;
    x_vld = 0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk($sformatf("ff l_idx%0d", k), l_idx, k);
      chk($sformatf("ff m_idx%0d", k), m_idx, 7 - k);
      @(posedge clk); #1;
    end
    arst = 1;
    #1;
    chk_both("arst", 0, 0, 0, 0, 0, 1);
    @(negedge clk);
    arst = 0;
    x_vld = 1; x = 8'h01;
    @(posedge clk); #1;
    x_vld = 0;
    @(negedge clk);
    chk_both("post01", 1, 0, 1, 0, 1, 1);
    @(posedge clk); #1;
    @(negedge clk);
    chk_both("post01 idle", 0, 0, 0, 0, 0, 1);
    @(posedge clk); #1;

    // random traffic against an index-queue model
    for (int c = 0; c < 3000; c++) begin
      bit xr;
      x_vld = $urandom_range(0, 1);
      case ($urandom_range(0, 3))
        0: x = 8'h00;
        1: x = 8'h01 << $urandom_range(0, 7);
        2: x = 8'hFF;
        default: x = 8'($urandom);
      endcase
      idx_rdy = $urandom_range(0, 3) != 0;
      @(negedge clk);
      xr = ql.size() == 0 || (ql.size() == 1 && idx_rdy);
      chk_both($sformatf("rnd%0d", c), ql.size() != 0,
               ql.size() ? ql[0] : 0, ql.size() == 1,
               qm.size() ? qm[0] : 0, qm.size() == 1, xr);
      if (ql.size() != 0 && idx_rdy) begin
        void'(ql.pop_front());
        void'(qm.pop_front());
      end
      if (x_vld && xr) begin
        for (int i = 0; i < 8; i++) if (x[i]) ql.push_back(i);
        for (int i = 7; i >= 0; i--) if (x[i]) qm.push_back(i);
      end
      @(posedge clk); #1;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
